// File: rtl/nn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : nn_pkg                                                       |
// | Description : Shared constants and FSM state encoding for the on-chip MLP  |
// |               blocks (hidden layer, output neuron, loss and backprop).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package nn_pkg;

  // Network geometry
  localparam int N_IN  = 4;            // input features per hidden neuron
  localparam int N_HID = 8;            // hidden neurons

  // Number formats
  localparam int XW    = 8;            // feature width, unsigned integer
  localparam int WW    = 8;            // weight width, unsigned 1.7
  localparam int HW    = 10;           // activation width, saturating
  localparam int FRAC  = 7;            // weight fractional bits
  localparam int PW    = XW + WW;      // product width
  localparam int ACCW  = 18;           // accumulator width (4*255*255 fits)
  localparam int SHW   = ACCW - FRAC;  // width after dropping fraction bits

  // Derived sizes
  localparam int N_W   = N_IN * N_HID;
  localparam int NW_AW = $clog2(N_W);
  localparam int NI_AW = $clog2(N_IN);
  localparam int NH_AW = $clog2(N_HID);

  // Largest representable activation
  localparam logic [HW-1:0] HW_MAX = 10'd1023;

  // Sequencer states, shared with loss_calc and future backprop blocks
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_COMMIT = 2'd2
  } nn_state_t;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/mac_sat_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_sat_unit                                                 |
// | Description : Combinational multiply-accumulate step with fixed-point      |
// |               rescale and saturation to the activation range.             |
// | Ports       : i_acc      - running accumulator (ACCW bits)                 |
// |               i_x        - feature operand, unsigned integer               |
// |               i_w        - weight operand, unsigned 1.7                    |
// |               o_acc_next - i_acc + i_x*i_w                                 |
// |               o_sat      - min(o_acc_next >> FRAC, HW_MAX)                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mac_sat_unit
  import nn_pkg::*;
(
  input  logic [ACCW-1:0] i_acc,
  input  logic [XW-1:0]   i_x,
  input  logic [WW-1:0]   i_w,
  output logic [ACCW-1:0] o_acc_next,
  output logic [HW-1:0]   o_sat
);

  logic [PW-1:0]  w_prod;
  logic [SHW-1:0] w_shift;

  // Both operands are unsigned; the 16-bit context zero-extends them.
  assign w_prod     = i_x * i_w;
  assign o_acc_next = i_acc + {{(ACCW-PW){1'b0}}, w_prod};

  // Dropping the fraction bits truncates toward zero (no rounding).
  assign w_shift    = o_acc_next[ACCW-1:FRAC];
  assign o_sat      = (w_shift > {1'b0, HW_MAX}) ? HW_MAX : w_shift[HW-1:0];

endmodule : mac_sat_unit
`default_nettype wire

// File: rtl/hidden_layer_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hidden_layer_seq                                             |
// | Description : Sequential MLP hidden layer. Computes 8 activations from 4   |
// |               features with one shared 8x8 multiplier, one product per     |
// |               cycle, and commits all results to h_o at once.              |
// | Ports       : clk_i     - clock                                            |
// |               rst_i     - asynchronous active-low reset                    |
// |               wr_en_i   - weight write strobe (honoured only when idle)    |
// |               wr_addr_i - weight index = neuron*N_IN + input              |
// |               wr_data_i - weight value, unsigned 1.7                      |
// |               x_i       - packed features, x[i] = x_i[8i+7:8i]            |
// |               start_i   - start one forward pass                          |
// |               busy_o    - pass in progress (MAC and COMMIT)               |
// |               done_o    - one-cycle pulse when h_o is updated             |
// |               h_o       - packed activations, h[n] = h_o[10n+9:10n]       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hidden_layer_seq
  import nn_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [NW_AW-1:0]      wr_addr_i,
  input  logic [WW-1:0]         wr_data_i,
  input  logic [N_IN*XW-1:0]    x_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [N_HID*HW-1:0]   h_o
);

  nn_state_t        r_state;
  nn_state_t        w_state_nxt;

  logic [XW-1:0]    r_x      [N_IN];
  logic [WW-1:0]    r_w      [N_W];
  logic [HW-1:0]    r_shadow [N_HID];
  logic [HW-1:0]    r_h      [N_HID];
  logic [ACCW-1:0]  r_acc;
  logic [NH_AW-1:0] r_n;
  logic [NI_AW-1:0] r_i;
  logic             r_done;

  logic [ACCW-1:0]  w_acc_next;
  logic [HW-1:0]    w_sat;
  logic [NW_AW-1:0] w_widx;
  logic             w_last_in;
  logic             w_last_neu;

  // Weight layout is neuron-major, so the index is just {n, i}.
  assign w_widx     = {r_n, r_i};
  assign w_last_in  = (r_i == NI_AW'(N_IN - 1));
  assign w_last_neu = (r_n == NH_AW'(N_HID - 1));

  mac_sat_unit u_mac (
    .i_acc      (r_acc),
    .i_x        (r_x[r_i]),
    .i_w        (r_w[w_widx]),
    .o_acc_next (w_acc_next),
    .o_sat      (w_sat)
  );

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_MAC;
        end
      end
      ST_MAC: begin
        if (w_last_in && w_last_neu) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: weight file, feature latch, accumulator, shadow and output regs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < N_W; k++) begin
        r_w[k] <= '0;
      end
      for (int k = 0; k < N_IN; k++) begin
        r_x[k] <= '0;
      end
      for (int k = 0; k < N_HID; k++) begin
        r_shadow[k] <= '0;
        r_h[k]      <= '0;
      end
      r_acc  <= '0;
      r_n    <= '0;
      r_i    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A start on the same edge as a write takes priority; the write
          // is discarded so the pass sees a stable weight set.
          if (start_i) begin
            for (int k = 0; k < N_IN; k++) begin
              r_x[k] <= x_i[k*XW +: XW];
            end
            r_acc <= '0;
            r_n   <= '0;
            r_i   <= '0;
          end else if (wr_en_i) begin
            r_w[wr_addr_i] <= wr_data_i;
          end
        end
        ST_MAC: begin
          if (w_last_in) begin
            r_shadow[r_n] <= w_sat;
            r_acc         <= '0;
            r_i           <= '0;
            r_n           <= r_n + 1'b1;
          end else begin
            r_acc <= w_acc_next;
            r_i   <= r_i + 1'b1;
          end
        end
        ST_COMMIT: begin
          // All activations move together so downstream never sees a mix
          // of old and new results.
          for (int k = 0; k < N_HID; k++) begin
            r_h[k] <= r_shadow[k];
          end
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = (r_state != ST_IDLE);
  assign done_o = r_done;

  for (genvar g = 0; g < N_HID; g++) begin : g_pack
    assign h_o[g*HW +: HW] = r_h[g];
  end

endmodule : hidden_layer_seq
`default_nettype wire
